mac_rx_framer: RTL and testbench

// - Receive MAC framing stage. Sits directly downstream of the PCS RX XGMII output (32-bit, 1 word/clk with valid).
// - Detects /S/ + preamble + SFD, strips them, and forwards payload+FCS as an AXI-Stream beat sequence with tkeep/tlast.
// - Flags malformed, errored and oversize frames on tuser and with a status pulse. No CRC check (downstream block).
// - No backpressure: the consumer must accept every beat.

---
 rtl/mac_rx_framer.sv | 218 +++++++++++++++++++++
 tb/tb_mac_rx_framer.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_rx_framer.sv
// mac_rx_framer: strips /S/, preamble and SFD from 32-bit XGMII RX words and
// forwards payload+FCS as AXI-Stream beats, flagging aborted/oversize frames.
`default_nettype none

module mac_rx_framer #(
  parameter int MAX_FRAME_BYTES = 1522
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [31:0] i_xgmii_data,
  input  logic [3:0]  i_xgmii_ctl,
  input  logic        i_xgmii_valid,
  input  logic [3:0]  i_term_loc,
  output logic [31:0] o_tdata,
  output logic [3:0]  o_tkeep,
  output logic        o_tvalid,
  output logic        o_tlast,
  output logic        o_tuser,
  output logic        o_frame_good,
  output logic        o_frame_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2,
    DROP     = 2'd3
  } state_t;

  localparam logic [16:0] MAX_BYTES = 17'(MAX_FRAME_BYTES);

  state_t      state, state_nxt;
  logic [31:0] hold_data, hold_data_nxt;
  logic [3:0]  hold_keep, hold_keep_nxt;
  logic        hold_valid, hold_valid_nxt;
  logic        flush_pending, flush_nxt;
  logic [15:0] byte_count, byte_count_nxt;

  logic [31:0] tdata_nxt;
  logic [3:0]  tkeep_nxt;
  logic        tvalid_nxt, tlast_nxt, tuser_nxt, good_nxt, err_nxt;

  logic [2:0]  term_lane;
  logic        term_onehot;
  logic [3:0]  below_mask;
  logic [31:0] part_data;
  logic [16:0] sum_full, sum_part;
  logic        abort;

  always_comb begin
    term_lane   = 3'd0;
    term_onehot = 1'b1;
    case (i_term_loc)
      4'b0001: term_lane = 3'd0;
      4'b0010: term_lane = 3'd1;
      4'b0100: term_lane = 3'd2;
      4'b1000: term_lane = 3'd3;
      default: term_onehot = 1'b0;
    endcase
  end

  // For a one-hot /T/ location, term_loc-1 marks exactly the data lanes before it.
  assign below_mask = i_term_loc - 4'd1;
  assign part_data  = i_xgmii_data & {{8{below_mask[3]}}, {8{below_mask[2]}},
                                      {8{below_mask[1]}}, {8{below_mask[0]}}};
  assign sum_full   = {1'b0, byte_count} + 17'd4;
  assign sum_part   = {1'b0, byte_count} + {14'd0, term_lane};

  function automatic logic [15:0] sat16(input logic [16:0] v);
    return v[16] ? 16'hFFFF : v[15:0];
  endfunction

  always_comb begin
    state_nxt      = state;
    hold_data_nxt  = hold_data;
    hold_keep_nxt  = hold_keep;
    hold_valid_nxt = hold_valid;
    flush_nxt      = 1'b0;
    byte_count_nxt = byte_count;
    tdata_nxt      = 32'd0;
    tkeep_nxt      = 4'd0;
    tvalid_nxt     = 1'b0;
    tlast_nxt      = 1'b0;
    tuser_nxt      = 1'b0;
    good_nxt       = 1'b0;
    err_nxt        = 1'b0;
    abort          = 1'b0;

    // The tail of a frame ending mid-word goes out one cycle late, valid or not.
    if (flush_pending) begin
      tvalid_nxt     = 1'b1;
      tdata_nxt      = hold_data;
      tkeep_nxt      = hold_keep;
      tlast_nxt      = 1'b1;
      good_nxt       = 1'b1;
      hold_valid_nxt = 1'b0;
    end

    if (i_xgmii_valid) begin
      case (state)
        IDLE: begin
          if (i_xgmii_ctl == 4'b0001 && i_xgmii_data == 32'h555555FB) begin
            state_nxt      = PREAMBLE;
            byte_count_nxt = 16'd0;
          end
        end
        PREAMBLE: begin
          hold_valid_nxt = 1'b0;
          if (i_xgmii_ctl == 4'd0 && i_xgmii_data == 32'hD5555555) begin
            state_nxt = DATA;
          end else begin
            state_nxt = IDLE;
            err_nxt   = 1'b1;
          end
        end
        DATA: begin
          if (i_term_loc == 4'd0) begin
            if (i_xgmii_ctl != 4'd0 || sum_full > MAX_BYTES) begin
              abort = 1'b1;
            end else begin
              if (hold_valid) begin
                tvalid_nxt = 1'b1;
                tdata_nxt  = hold_data;
                tkeep_nxt  = 4'hF;
              end
              hold_data_nxt  = i_xgmii_data;
              hold_keep_nxt  = 4'hF;
              hold_valid_nxt = 1'b1;
              byte_count_nxt = sat16(sum_full);
            end
          end else if (!term_onehot || (i_xgmii_ctl & below_mask) != 4'd0) begin
            abort = 1'b1;
          end else if (term_lane == 3'd0) begin
            state_nxt      = IDLE;
            hold_valid_nxt = 1'b0;
            if (hold_valid) begin
              tvalid_nxt = 1'b1;
              tdata_nxt  = hold_data;
              tkeep_nxt  = 4'hF;
              tlast_nxt  = 1'b1;
              good_nxt   = 1'b1;
            end else begin
              err_nxt = 1'b1;
            end
          end else if (sum_part > MAX_BYTES) begin
            abort = 1'b1;
          end else begin
            if (hold_valid) begin
              tvalid_nxt = 1'b1;
              tdata_nxt  = hold_data;
              tkeep_nxt  = 4'hF;
            end
            hold_data_nxt  = part_data;
            hold_keep_nxt  = below_mask;
            hold_valid_nxt = 1'b1;
            flush_nxt      = 1'b1;
            byte_count_nxt = sat16(sum_part);
            state_nxt      = IDLE;
          end

          if (abort) begin
            if (hold_valid) begin
              tvalid_nxt = 1'b1;
              tdata_nxt  = hold_data;
              tkeep_nxt  = 4'hF;
              tlast_nxt  = 1'b1;
              tuser_nxt  = 1'b1;
            end
            err_nxt        = 1'b1;
            hold_valid_nxt = 1'b0;
            state_nxt      = DROP;
          end
        end
        DROP: begin
          if (i_term_loc != 4'd0 || i_xgmii_ctl == 4'hF) begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state         <= IDLE;
      hold_data     <= 32'd0;
      hold_keep     <= 4'd0;
      hold_valid    <= 1'b0;
      flush_pending <= 1'b0;
      byte_count    <= 16'd0;
      o_tdata       <= 32'd0;
      o_tkeep       <= 4'd0;
      o_tvalid      <= 1'b0;
      o_tlast       <= 1'b0;
      o_tuser       <= 1'b0;
      o_frame_good  <= 1'b0;
      o_frame_err   <= 1'b0;
    end else begin
      state         <= state_nxt;
      hold_data     <= hold_data_nxt;
      hold_keep     <= hold_keep_nxt;
      hold_valid    <= hold_valid_nxt;
      flush_pending <= flush_nxt;
      byte_count    <= byte_count_nxt;
      o_tdata       <= tdata_nxt;
      o_tkeep       <= tkeep_nxt;
      o_tvalid      <= tvalid_nxt;
      o_tlast       <= tlast_nxt;
      o_tuser       <= tuser_nxt;
      o_frame_good  <= good_nxt;
      o_frame_err   <= err_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mac_rx_framer.sv
// tb_mac_rx_framer: directed frames into a default-size and a 64-byte-limit framer.
`default_nettype none

module tb_mac_rx_framer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] xd;
  logic [3:0]  xc;
  logic        xv;
  logic [3:0]  tl;

  logic [31:0] a_tdata, b_tdata;
  logic [3:0]  a_tkeep, b_tkeep;
  logic        a_tvalid, a_tlast, a_tuser, a_good, a_err;
  logic        b_tvalid, b_tlast, b_tuser, b_good, b_err;

  always #5 clk = ~clk;

  mac_rx_framer dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_xgmii_data(xd), .i_xgmii_ctl(xc),
    .i_xgmii_valid(xv), .i_term_loc(tl),
    .o_tdata(a_tdata), .o_tkeep(a_tkeep), .o_tvalid(a_tvalid), .o_tlast(a_tlast),
    .o_tuser(a_tuser), .o_frame_good(a_good), .o_frame_err(a_err)
  );

  mac_rx_framer #(.MAX_FRAME_BYTES(64)) dut_small (
    .i_clk(clk), .i_reset_n(reset_n), .i_xgmii_data(xd), .i_xgmii_ctl(xc),
    .i_xgmii_valid(xv), .i_term_loc(tl),
    .o_tdata(b_tdata), .o_tkeep(b_tkeep), .o_tvalid(b_tvalid), .o_tlast(b_tlast),
    .o_tuser(b_tuser), .o_frame_good(b_good), .o_frame_err(b_err)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic        user;
  } beat_t;

  int    compared = 0;
  int    mismatched = 0;
  beat_t qa[$];
  beat_t qb[$];
  bit    va[$];
  int    a_goods = 0, a_errs = 0, b_goods = 0, b_errs = 0, both_hi = 0;
  logic  sampled_valid;

  always @(posedge clk) sampled_valid <= xv;

  always @(negedge clk) begin
    if (a_tvalid === 1'b1) begin
      qa.push_back({a_tdata, a_tkeep, a_tlast, a_tuser});
      va.push_back(sampled_valid);
    end
    if (b_tvalid === 1'b1) qb.push_back({b_tdata, b_tkeep, b_tlast, b_tuser});
    if (a_good === 1'b1) a_goods++;
    if (a_err === 1'b1) a_errs++;
    if (b_good === 1'b1) b_goods++;
    if (b_err === 1'b1) b_errs++;
    if ((a_good & a_err) === 1'b1 || (b_good & b_err) === 1'b1) both_hi++;
  end

  function automatic logic [31:0] word(input int base, input int i);
    int b;
    b = base + 4 * i;
    return {8'(b + 3), 8'(b + 2), 8'(b + 1), 8'(b)};
  endfunction

  task automatic send(input logic [31:0] d, input logic [3:0] c, input logic [3:0] t,
                      input logic v);
    xd = d; xc = c; tl = t; xv = v;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) send(32'h07070707, 4'hF, 4'h0, 1'b1);
  endtask

  task automatic send_start();
    send(32'h555555FB, 4'h1, 4'h0, 1'b1);
    send(32'hD5555555, 4'h0, 4'h0, 1'b1);
  endtask

  task automatic send_term0();
    send(32'h070707FD, 4'hF, 4'h1, 1'b1);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle(3);
    compared++;
    if ({a_tdata, a_tkeep, a_tvalid, a_tlast, a_tuser, a_good, a_err} !== 41'd0) begin
      mismatched++;
      $display("FAIL reset_outputs got %h required 0",
               {a_tdata, a_tkeep, a_tvalid, a_tlast, a_tuser, a_good, a_err});
    end
    compared++;
    if ({b_tdata, b_tkeep, b_tvalid, b_tlast, b_tuser, b_good, b_err} !== 41'd0) begin
      mismatched++;
      $display("FAIL reset_outputs_small got %h required 0",
               {b_tdata, b_tkeep, b_tvalid, b_tlast, b_tuser, b_good, b_err});
    end
    reset_n = 1'b1;
    idle(2);
  endtask

  task automatic test_frame64(input bit gapped);
    int na, nb, ga, ea, gb;
    beat_t exp;
    na = qa.size(); nb = qb.size(); ga = a_goods; ea = a_errs; gb = b_goods;
    send(32'h555555FB, 4'h1, 4'h0, 1'b1);
    if (gapped) send(32'hDEADBEEF, 4'h0, 4'h0, 1'b0);
    send(32'hD5555555, 4'h0, 4'h0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      if (gapped) send(32'hDEADBEEF, 4'h0, 4'h0, 1'b0);
      send(word(16, i), 4'h0, 4'h0, 1'b1);
    end
    if (gapped) send(32'hDEADBEEF, 4'h0, 4'h0, 1'b0);
    send_term0();
    idle(3);
    compared++;
    if (qa.size() - na != 16) begin
      mismatched++;
      $display("FAIL f64_beats gapped=%0d got %0d required 16", gapped, qa.size() - na);
    end
    for (int i = 0; i < 16 && na + i < qa.size(); i++) begin
      exp = {word(16, i), 4'hF, 1'(i == 15), 1'b0};
      compared++;
      if (qa[na + i] !== exp) begin
        mismatched++;
        $display("FAIL f64_beat%0d gapped=%0d got %h required %h", i, gapped, qa[na + i], exp);
      end
      if (gapped) begin
        compared++;
        if (va[na + i] !== 1'b1) begin
          mismatched++;
          $display("FAIL gap_beat%0d_after_invalid got 0 required 1", i);
        end
      end
    end
    compared++;
    if (a_goods - ga != 1 || a_errs - ea != 0) begin
      mismatched++;
      $display("FAIL f64_pulses got good=%0d err=%0d required 1/0", a_goods - ga, a_errs - ea);
    end
    compared++;
    if (qb.size() - nb != 16 || b_goods - gb != 1) begin
      mismatched++;
      $display("FAIL f64_at_limit got beats=%0d good=%0d required 16/1",
               qb.size() - nb, b_goods - gb);
    end
  endtask

  task automatic test_frame61();
    int na, ga;
    beat_t got;
    na = qa.size(); ga = a_goods;
    send_start();
    for (int i = 0; i < 15; i++) send(word(64, i), 4'h0, 4'h0, 1'b1);
    send({8'h07, 8'h07, 8'hFD, 8'(64 + 60)}, 4'b1110, 4'b0010, 1'b1);
    idle(3);
    compared++;
    if (qa.size() - na != 16) begin
      mismatched++;
      $display("FAIL f61_beats got %0d required 16", qa.size() - na);
    end else begin
      compared++;
      if (qa[na + 14] !== {word(64, 14), 4'hF, 1'b0, 1'b0}) begin
        mismatched++;
        $display("FAIL f61_beat14 got %h required %h", qa[na + 14],
                 {word(64, 14), 4'hF, 1'b0, 1'b0});
      end
      got = qa[na + 15];
      compared++;
      if ({got.data[7:0], got.keep, got.last, got.user} !== {8'(64 + 60), 4'b0001, 1'b1, 1'b0}) begin
        mismatched++;
        $display("FAIL f61_last got byte=%h keep=%b last=%b user=%b required 7c/0001/1/0",
                 got.data[7:0], got.keep, got.last, got.user);
      end
    end
    compared++;
    if (a_goods - ga != 1) begin
      mismatched++;
      $display("FAIL f61_good got %0d required 1", a_goods - ga);
    end
  endtask

  task automatic test_partial_lanes();
    int na, ga;
    logic [31:0] w, m;
    logic [3:0]  c, t;
    beat_t exp;
    for (int k = 2; k <= 3; k++) begin
      na = qa.size(); ga = a_goods;
      w = 32'h07070707;
      for (int j = 0; j < k; j++) w[8*j +: 8] = 8'(160 + 8 + j);
      w[8*k +: 8] = 8'hFD;
      c = 4'hF << k;
      t = 4'b0001 << k;
      m = (k == 2) ? 32'h0000FFFF : 32'h00FFFFFF;
      send_start();
      send(word(160, 0), 4'h0, 4'h0, 1'b1);
      send(word(160, 1), 4'h0, 4'h0, 1'b1);
      send(w, c, t, 1'b1);
      idle(3);
      exp = {word(160, 2) & m, 4'(m[31:0] == 32'h0000FFFF ? 4'b0011 : 4'b0111), 1'b1, 1'b0};
      compared++;
      if (qa.size() - na != 3) begin
        mismatched++;
        $display("FAIL partial_k%0d_beats got %0d required 3", k, qa.size() - na);
      end else begin
        compared++;
        if ({qa[na + 2].data & m, qa[na + 2].keep, qa[na + 2].last, qa[na + 2].user} !== exp) begin
          mismatched++;
          $display("FAIL partial_k%0d_last got %h required %h", k, qa[na + 2], exp);
        end
      end
      compared++;
      if (a_goods - ga != 1) begin
        mismatched++;
        $display("FAIL partial_k%0d_good got %0d required 1", k, a_goods - ga);
      end
    end
  endtask

  task automatic test_bad_sfd();
    int na, ga, ea;
    na = qa.size(); ga = a_goods; ea = a_errs;
    send(32'h555555FB, 4'h1, 4'h0, 1'b1);
    send(32'hD4555555, 4'h0, 4'h0, 1'b1);
    for (int i = 0; i < 3; i++) send(word(32, i), 4'h0, 4'h0, 1'b1);
    send_term0();
    idle(2);
    compared++;
    if (qa.size() - na != 0 || a_goods - ga != 0 || a_errs - ea != 1) begin
      mismatched++;
      $display("FAIL bad_sfd got beats=%0d good=%0d err=%0d required 0/0/1",
               qa.size() - na, a_goods - ga, a_errs - ea);
    end
  endtask

  task automatic test_empty_frame();
    int na, ga, ea;
    na = qa.size(); ga = a_goods; ea = a_errs;
    send_start();
    send_term0();
    idle(2);
    compared++;
    if (qa.size() - na != 0 || a_goods - ga != 0 || a_errs - ea != 1) begin
      mismatched++;
      $display("FAIL empty_frame got beats=%0d good=%0d err=%0d required 0/0/1",
               qa.size() - na, a_goods - ga, a_errs - ea);
    end
  endtask

  task automatic test_error_char();
    int na, ga, ea;
    logic [31:0] w;
    beat_t exp;
    na = qa.size(); ga = a_goods; ea = a_errs;
    send_start();
    for (int i = 0; i < 4; i++) send(word(128, i), 4'h0, 4'h0, 1'b1);
    w = word(128, 4);
    w[23:16] = 8'hFE;
    send(w, 4'b0100, 4'h0, 1'b1);
    for (int i = 5; i < 8; i++) send(word(128, i), 4'h0, 4'h0, 1'b1);
    send_term0();
    idle(3);
    compared++;
    if (qa.size() - na != 4) begin
      mismatched++;
      $display("FAIL errchar_beats got %0d required 4", qa.size() - na);
    end else begin
      exp = {word(128, 3), 4'hF, 1'b1, 1'b1};
      compared++;
      if (qa[na + 3] !== exp) begin
        mismatched++;
        $display("FAIL errchar_beat4 got %h required %h", qa[na + 3], exp);
      end
      compared++;
      if (qa[na + 2] !== {word(128, 2), 4'hF, 1'b0, 1'b0}) begin
        mismatched++;
        $display("FAIL errchar_beat3 got %h required %h", qa[na + 2],
                 {word(128, 2), 4'hF, 1'b0, 1'b0});
      end
    end
    compared++;
    if (a_goods - ga != 0 || a_errs - ea != 1) begin
      mismatched++;
      $display("FAIL errchar_pulses got good=%0d err=%0d required 0/1", a_goods - ga, a_errs - ea);
    end
  endtask

  task automatic test_oversize();
    int na, nb, ga, gb, eb;
    beat_t exp;
    na = qa.size(); nb = qb.size(); ga = a_goods; gb = b_goods; eb = b_errs;
    send_start();
    for (int i = 0; i < 17; i++) send(word(192, i), 4'h0, 4'h0, 1'b1);
    send_term0();
    idle(3);
    compared++;
    if (qb.size() - nb != 16) begin
      mismatched++;
      $display("FAIL oversize_beats got %0d required 16", qb.size() - nb);
    end else begin
      exp = {word(192, 15), 4'hF, 1'b1, 1'b1};
      compared++;
      if (qb[nb + 15] !== exp) begin
        mismatched++;
        $display("FAIL oversize_last got %h required %h", qb[nb + 15], exp);
      end
    end
    compared++;
    if (b_goods - gb != 0 || b_errs - eb != 1) begin
      mismatched++;
      $display("FAIL oversize_pulses got good=%0d err=%0d required 0/1", b_goods - gb, b_errs - eb);
    end
    compared++;
    if (qa.size() - na != 17 || a_goods - ga != 1) begin
      mismatched++;
      $display("FAIL f68_default got beats=%0d good=%0d required 17/1",
               qa.size() - na, a_goods - ga);
    end
  endtask

  task automatic test_reset_mid();
    int na, ga, ea;
    na = qa.size(); ga = a_goods; ea = a_errs;
    send_start();
    for (int i = 0; i < 5; i++) send(word(224, i), 4'h0, 4'h0, 1'b1);
    reset_n = 1'b0;
    send(word(224, 5), 4'h0, 4'h0, 1'b1);
    compared++;
    if (a_tvalid !== 1'b0 || b_tvalid !== 1'b0) begin
      mismatched++;
      $display("FAIL midreset_tvalid got %b/%b required 0/0", a_tvalid, b_tvalid);
    end
    reset_n = 1'b1;
    for (int i = 6; i < 10; i++) send(word(224, i), 4'h0, 4'h0, 1'b1);
    send_term0();
    idle(3);
    compared++;
    if (qa.size() - na != 4 || a_goods - ga != 0 || a_errs - ea != 0) begin
      mismatched++;
      $display("FAIL midreset_after got beats=%0d good=%0d err=%0d required 4/0/0",
               qa.size() - na, a_goods - ga, a_errs - ea);
    end
    for (int i = na; i < qa.size(); i++) begin
      compared++;
      if (qa[i].last !== 1'b0) begin
        mismatched++;
        $display("FAIL midreset_tlast beat%0d got 1 required 0", i - na);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    xd = 32'h07070707; xc = 4'hF; tl = 4'h0; xv = 1'b1;
    test_reset();
    test_frame64(1'b0);
    test_frame61();
    test_partial_lanes();
    test_frame64(1'b1);
    test_bad_sfd();
    test_frame64(1'b0);
    test_empty_frame();
    test_error_char();
    test_oversize();
    test_reset_mid();
    compared++;
    if (both_hi != 0) begin
      mismatched++;
      $display("FAIL good_err_overlap got %0d required 0", both_hi);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
